// File: rtl/bcond_flag_sequencer.sv
// B.cond resolution sequencer for the LEGv8 pipeline: holds NZCV, tracks in-flight
// flag writers, stalls a B.cond until its flags are final, and drives a multi-cycle flush.
module bcond_flag_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PEND_W       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        setflags_issue,
  input  logic        flags_wb_valid,
  input  logic [3:0]  flags_wb,
  input  logic        bcond_valid,
  input  logic [4:0]  bcond_code,
  output logic [3:0]  nzcv,
  output logic        setflags_stall,
  output logic        stall,
  output logic        br_resolved,
  output logic        br_taken,
  output logic        flush
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state;
  logic [PEND_W-1:0] pend;
  logic [2:0]        fcnt;
  logic [3:0]        eff_flags;
  logic              flags_ready;
  logic              cond_true;
  logic              active;
  logic              f_n, f_z, f_c, f_v;

  always_comb begin
    eff_flags = flags_wb_valid ? flags_wb : nzcv;
    {f_n, f_z, f_c, f_v} = eff_flags;
    flags_ready = (pend == '0) ||
                  ((pend == PEND_W'(1)) && flags_wb_valid && !setflags_issue);
    cond_true = 1'b0;
    case (bcond_code)
      5'd0:    cond_true = f_z;
      5'd1:    cond_true = !f_z;
      5'd2:    cond_true = f_c;
      5'd3:    cond_true = !f_c;
      5'd4:    cond_true = f_n;
      5'd5:    cond_true = !f_n;
      5'd6:    cond_true = f_v;
      5'd7:    cond_true = !f_v;
      5'd8:    cond_true = f_c && !f_z;
      5'd9:    cond_true = !(f_c && !f_z);
      5'd10:   cond_true = (f_n == f_v);
      5'd11:   cond_true = (f_n != f_v);
      5'd12:   cond_true = !f_z && (f_n == f_v);
      5'd13:   cond_true = !(!f_z && (f_n == f_v));
      default: cond_true = 1'b0;
    endcase
    // Mealy outputs are gated by reset so they drop the instant reset asserts.
    active      = reset && bcond_valid && (state != S_FLUSH);
    br_resolved = active && flags_ready;
    stall       = active && !flags_ready;
    br_taken    = br_resolved && cond_true;
  end

  assign setflags_stall = (pend == PEND_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv <= '0;
      pend <= '0;
    end else begin
      if (flags_wb_valid) nzcv <= flags_wb;
      if (setflags_issue && flags_wb_valid && (pend != '0))
        pend <= pend;
      else if (setflags_issue && (pend != PEND_MAX))
        pend <= pend + PEND_W'(1);
      else if (flags_wb_valid && (pend != '0))
        pend <= pend - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      fcnt  <= '0;
      flush <= 1'b0;
    end else begin
      case (state)
        // IDLE and WAIT resolve identically; WAIT only records that a stall is ongoing.
        S_IDLE, S_WAIT: begin
          if (br_resolved && br_taken) begin
            state <= S_FLUSH;
            fcnt  <= 3'(FLUSH_CYCLES);
            flush <= 1'b1;
          end else if (stall) begin
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (fcnt <= 3'd1) begin
            state <= S_IDLE;
            flush <= 1'b0;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcond_flag_sequencer.sv
// Bench for bcond_flag_sequencer: directed vector table, reset-in-WAIT sequence,
// then random traffic against a cycle-level reference model.
module tb_bcond_flag_sequencer;
  localparam int FC = 2;
  localparam int PW = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       setflags_issue, flags_wb_valid, bcond_valid;
  logic [3:0] flags_wb;
  logic [4:0] bcond_code;
  logic [3:0] nzcv;
  logic       setflags_stall, stall, br_resolved, br_taken, flush;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int       m_pend;
  int       m_fl;
  bit [3:0] m_nzcv;

  bcond_flag_sequencer #(.FLUSH_CYCLES(FC), .PEND_W(PW)) dut (
    .clk(clk), .reset(reset),
    .setflags_issue(setflags_issue), .flags_wb_valid(flags_wb_valid), .flags_wb(flags_wb),
    .bcond_valid(bcond_valid), .bcond_code(bcond_code),
    .nzcv(nzcv), .setflags_stall(setflags_stall), .stall(stall),
    .br_resolved(br_resolved), .br_taken(br_taken), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       issue, wbv;
    logic [3:0] wb;
    logic       bv;
    logic [4:0] code;
    logic       e_stall, e_res, e_taken, e_flush;
    logic [3:0] e_nzcv;
    logic       e_sfs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic i, logic w, logic [3:0] wb, logic b, logic [4:0] c,
                              logic es, logic er, logic et, logic ef, logic [3:0] en, logic esf);
    vec_t v;
    v.issue = i; v.wbv = w; v.wb = wb; v.bv = b; v.code = c;
    v.e_stall = es; v.e_res = er; v.e_taken = et; v.e_flush = ef; v.e_nzcv = en; v.e_sfs = esf;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic es, logic er, logic et, logic ef,
                           logic [3:0] en, logic esf);
    chk({tag, " stall"}, {3'b0, stall}, {3'b0, es});
    chk({tag, " br_resolved"}, {3'b0, br_resolved}, {3'b0, er});
    chk({tag, " br_taken"}, {3'b0, br_taken}, {3'b0, et});
    chk({tag, " flush"}, {3'b0, flush}, {3'b0, ef});
    chk({tag, " nzcv"}, nzcv, en);
    chk({tag, " setflags_stall"}, {3'b0, setflags_stall}, {3'b0, esf});
  endtask

  task automatic drive(logic i, logic w, logic [3:0] wb, logic b, logic [4:0] c);
    setflags_issue = i; flags_wb_valid = w; flags_wb = wb; bcond_valid = b; bcond_code = c;
  endtask

  // Condition truth: each pair of codes shares a base predicate; odd codes negate it.
  function automatic bit cond_of(logic [4:0] c, bit [3:0] f);
    bit n, z, cf, v;
    bit base [7];
    {n, z, cf, v} = f;
    if (c > 5'd13) return 1'b0;
    base = '{z, cf, n, v, cf & ~z, n == v, ~z & (n == v)};
    return base[int'(c) / 2] ^ c[0];
  endfunction

  function automatic bit m_ready(bit i, bit w);
    return (m_pend == 0) || (m_pend == 1 && w && !i);
  endfunction

  task automatic model_check(string tag);
    bit [3:0] f;
    bit fl, res, stl, tk;
    f   = flags_wb_valid ? flags_wb : m_nzcv;
    fl  = (m_fl > 0);
    res = bcond_valid && !fl && m_ready(setflags_issue, flags_wb_valid);
    stl = bcond_valid && !fl && !m_ready(setflags_issue, flags_wb_valid);
    tk  = res && cond_of(bcond_code, f);
    check_all(tag, stl, res, tk, fl, m_nzcv, m_pend == PMAX);
  endtask

  task automatic model_commit();
    bit [3:0] f;
    bit taken;
    f = flags_wb_valid ? flags_wb : m_nzcv;
    taken = bcond_valid && (m_fl == 0) && m_ready(setflags_issue, flags_wb_valid)
            && cond_of(bcond_code, f);
    if (flags_wb_valid) m_nzcv = flags_wb;
    if (setflags_issue && flags_wb_valid && m_pend > 0) m_pend = m_pend;
    else if (setflags_issue && m_pend < PMAX) m_pend = m_pend + 1;
    else if (flags_wb_valid && m_pend > 0) m_pend = m_pend - 1;
    if (taken) m_fl = FC;
    else if (m_fl > 0) m_fl = m_fl - 1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 4'h0, 0, 5'd0);
    m_pend = 0; m_fl = 0; m_nzcv = '0;

    //              iss wbv wb   bv code  stl res tk  fl  nzcv  sfs
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd0,  0,  1,  0,  0, 4'h0, 0)); // EQ after reset, not taken
    tbl.push_back(mk(0, 1, 4'h4, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0)); // write Z
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd0,  0,  1,  1,  0, 4'h4, 0)); // EQ taken
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h4, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h4, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h4, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h4, 0)); // issue
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd12, 1,  0,  0,  0, 4'h4, 0)); // GT waits
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd12, 1,  0,  0,  0, 4'h4, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd12, 1,  0,  0,  0, 4'h4, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 5'd12, 0,  1,  1,  0, 4'h4, 0)); // bypass resolve
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0)); // fill counter
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 1)); // full, issue dropped
    tbl.push_back(mk(0, 1, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd1,  0,  1,  1,  0, 4'h0, 0)); // pend 0: NE resolves
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0)); // pend=1
    tbl.push_back(mk(1, 1, 4'h4, 1, 5'd0,  1,  0,  0,  0, 4'h0, 0)); // issue+wb: not ready
    tbl.push_back(mk(0, 0, 4'h0, 1, 5'd0,  1,  0,  0,  0, 4'h4, 0)); // pend still 1
    tbl.push_back(mk(0, 1, 4'h0, 1, 5'd20, 0,  1,  0,  0, 4'h4, 0)); // code 20 never taken
    tbl.push_back(mk(0, 0, 4'h0, 0, 5'd0,  0,  0,  0,  0, 4'h0, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 4'h0, 0);
    reset = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].issue, tbl[k].wbv, tbl[k].wb, tbl[k].bv, tbl[k].code);
      #4;
      check_all($sformatf("vec%0d", k), tbl[k].e_stall, tbl[k].e_res, tbl[k].e_taken,
                tbl[k].e_flush, tbl[k].e_nzcv, tbl[k].e_sfs);
      @(posedge clk);
      model_commit();
      #1;
    end

    // Reset asserted while a B.cond is stalled in WAIT.
    drive(1, 0, 4'h0, 0, 5'd0);
    @(posedge clk); model_commit(); #1;
    drive(0, 0, 4'h0, 1, 5'd0);
    #4;
    check_all("wait_enter", 1, 0, 0, 0, 4'h0, 0);
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check_all("reset_in_wait", 0, 0, 0, 0, 4'h0, 0);
    m_pend = 0; m_fl = 0; m_nzcv = '0;
    drive(0, 0, 4'h0, 0, 5'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 0, 4'h0, 1, 5'd0);
    #4;
    check_all("after_reset_eq", 0, 1, 0, 0, 4'h0, 0);
    @(posedge clk); model_commit(); #1;

    for (int c = 0; c < 3000; c++) begin
      logic [4:0] code;
      code = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), 4'($urandom),
            ($urandom_range(0, 9) < 7), code);
      #4;
      model_check("rand");
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bcond_flag_sequencer.md
# bcond_flag_sequencer

Sequences conditional-branch resolution in the LEGv8 pipeline. Holds the architectural NZCV register and counts in-flight flag-setting instructions (ADDS/SUBS/ANDS). It stalls a B.cond in decode until its flags are final, evaluates the condition using the pipeline's 5-bit condition encoding, and drives a multi-cycle flush when the branch is taken.

## Interface
- FLUSH_CYCLES, 2: number of consecutive cycles `flush` is held after a taken branch (1..7).
- PEND_W, 2: width of the pending flag-writer counter; maximum outstanding = 2^PEND_W − 1.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- setflags_issue  in  1  a flag-setting instruction leaves decode this cycle.
- flags_wb_valid  in  1  a flag-setting instruction writes its flags this cycle.
- flags_wb  in  4  {N,Z,C,V} accompanying `flags_wb_valid`.
- bcond_valid  in  1  a B.cond sits in decode; held until `br_resolved`.
- bcond_code  in  5  condition code: 0 EQ, 1 NE, 2 HS, 3 LO, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, 10 GE, 11 LT, 12 GT, 13 LE; 14–31 never taken.
- nzcv  out  4  architectural flags {N,Z,C,V}.
- setflags_stall  out  1  pending counter full; upstream must not issue.
- stall  out  1  hold decode/fetch; B.cond is waiting for flags.
- br_resolved  out  1  one-cycle pulse: the B.cond was evaluated this cycle.
- br_taken  out  1  valid with `br_resolved`; 1 = redirect.
- flush  out  1  squash younger instructions.

## Operation
- Reset values: `nzcv`=0000, pend=0, state IDLE. All outputs are 0, except `setflags_stall`, which is 0 because pend=0.
- `flags_wb_valid` loads `nzcv` ← `flags_wb` at the clock edge.
- Pending counter:
  - +1 on issue, −1 on writeback; both in the same cycle leaves it unchanged.
  - Issue while full is dropped and the counter saturates.
  - Writeback at 0 is ignored and the counter stays 0.
- `setflags_stall` = (pend == 2^PEND_W − 1), combinational from the counter.
- Effective flags F for evaluation: `flags_wb` if `flags_wb_valid`, else `nzcv` (writeback bypass).
- Flags are final ("ready") when pend==0, or when pend==1 with `flags_wb_valid`=1 and `setflags_issue`=0.
- Condition evaluation:
  - HI = C & ~Z; LS = ~HI.
  - GE = (N==V); LT = ~GE.
  - GT = ~Z & GE; LE = ~GT.
  - The rest follow the direct/negated single-flag rule implied by the code list.
- FSM states:
  - IDLE:
    - `bcond_valid` & ready → resolve (`br_resolved`=1, `br_taken`=cond(F)).
    - If taken, go to FLUSH with count ← FLUSH_CYCLES; otherwise stay in IDLE.
    - `bcond_valid` & not ready → go to WAIT with `stall`=1 in this same cycle.
  - WAIT:
    - `stall`=1 every cycle.
    - When ready, resolve as in IDLE (same cycle, `stall`=0) and go to IDLE or FLUSH.
    - `bcond_valid` dropping while in WAIT returns to IDLE with no resolution.
  - FLUSH:
    - `flush`=1 for exactly FLUSH_CYCLES cycles, then IDLE.
    - `bcond_valid` is ignored. The counter and `nzcv` keep updating normally.
- Asynchronous reset in any state returns to IDLE immediately; a pending branch is discarded.

## Timing
- `br_resolved`, `br_taken` and `stall` are combinational (Mealy) in the resolving cycle.
- `flush` is registered: it asserts the cycle after a taken resolve.
- Zero-wait latency: B.cond resolves in its first decode cycle.
- With a pending writer, resolution occurs in the writeback cycle via bypass, not one cycle later.
- `nzcv` updates one edge after `flags_wb_valid`.

## Test plan
- Reset with `nzcv`=0000, then `bcond_valid`=1, code 0 (EQ) → `br_resolved`=1, `br_taken`=0, `stall`=0, no flush.
- Cycle 0: `flags_wb_valid`=1, `flags_wb`=0100. Cycle 1: EQ → taken. `flush`=1 in cycles 2–3 (FLUSH_CYCLES=2), then 0.
- `setflags_issue` at cycle 0, B.cond GT at cycle 1 → `stall`=1 in cycles 1–3. Cycle 4: `flags_wb_valid`, `flags_wb`=0000 → `br_resolved`=1, `br_taken`=1 in cycle 4, `stall`=0.
- Three issues with no writeback (PEND_W=2) → `setflags_stall`=1. A fourth issue is dropped. Three writebacks → pend=0 and `setflags_stall`=0 after the third.
- Cycle with issue and writeback together at pend=1 → pend stays 1. A B.cond in that cycle is not resolved; `stall`=1.
- Code 20 with any flags → resolved not-taken. Reset asserted during WAIT → all outputs 0 immediately, state IDLE.
